// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared encodings for the ID-stage branch hazard controller: branch classes,
// FSM states and the taken-condition decode.
package branch_hazard_ctrl_pkg;

    localparam int REG_W_DEF = 5;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BGTZ = 3'd3,
        BR_BLEZ = 3'd4,
        BR_BGEZ = 3'd5,
        BR_BLTZ = 3'd6,
        BR_JR   = 3'd7
    } br_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STALL   = 2'd1,
        ST_RESOLVE = 2'd2
    } state_e;

    function automatic logic br_taken(input br_op_e op, input logic rsgz,
                                      input logic tes, input logic rsez);
        logic t;
        t = 1'b0;
        case (op)
            BR_BEQ:  t = tes;
            BR_BNE:  t = !tes;
            BR_BGTZ: t = rsgz;
            BR_BLEZ: t = !rsgz;
            BR_BGEZ: t = rsgz | rsez;
            BR_BLTZ: t = !rsgz & !rsez;
            BR_JR:   t = 1'b1;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/branch_hazard_ctrl_if.sv
// ID-stage branch bus: decoded branch, comparator flags, EX/MEM hazard info
// and the resulting pipeline controls.
interface branch_hazard_ctrl_if
    import branch_hazard_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
);
    logic             id_valid;
    br_op_e           br_op;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             rsgz;
    logic             tes;
    logic             rsez;
    logic             ex_regwrite;
    logic             ex_memread;
    logic [REG_W-1:0] ex_rd;
    logic             mem_memread;
    logic [REG_W-1:0] mem_rd;
    logic             stall;
    logic             pc_sel;
    logic             flush_ifid;

    modport master (
        output id_valid, br_op, id_rs, id_rt, rsgz, tes, rsez,
               ex_regwrite, ex_memread, ex_rd, mem_memread, mem_rd,
        input  stall, pc_sel, flush_ifid
    );

    modport slave (
        input  id_valid, br_op, id_rs, id_rt, rsgz, tes, rsez,
               ex_regwrite, ex_memread, ex_rd, mem_memread, mem_rd,
        output stall, pc_sel, flush_ifid
    );
endinterface

// File: rtl/branch_hazard_ctrl_sat_counter.sv
// Saturating up-counter for performance debug; holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) count_d = count_q + W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count = count_q;
endmodule

// File: rtl/branch_hazard_ctrl.sv
// Branch/jump resolution in ID with load/ALU hazard stalling and
// saturating taken/stall counters.
module branch_hazard_ctrl
    import branch_hazard_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEF,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    branch_hazard_ctrl_if.slave  bus,
    output logic [CNT_W-1:0]     taken_cnt,
    output logic [CNT_W-1:0]     stall_cnt
);
    state_e           state_d, state_q;
    logic [1:0]       cnt_d, cnt_q;
    logic [1:0]       need;
    logic [REG_W-1:0] rs, rt, ex_rd, mem_rd;
    logic             active, rs_used, rt_used, ex_hit, mem_hit, taken;
    logic             stall_o, pc_sel_o;

    assign rs     = bus.id_rs;
    assign rt     = bus.id_rt;
    assign ex_rd  = bus.ex_rd;
    assign mem_rd = bus.mem_rd;

    // Hazard depth: a load in EX needs two cycles, anything else one.
    always_comb begin
        rs_used = (bus.br_op != BR_NONE);
        rt_used = (bus.br_op == BR_BEQ) || (bus.br_op == BR_BNE);
        active  = bus.id_valid && rs_used;
        ex_hit  = (ex_rd != '0) &&
                  ((rs_used && (ex_rd == rs)) || (rt_used && (ex_rd == rt)));
        mem_hit = (mem_rd != '0) &&
                  ((rs_used && (mem_rd == rs)) || (rt_used && (mem_rd == rt)));
        need    = 2'd0;
        if (bus.ex_memread && ex_hit)
            need = 2'd2;
        else if ((bus.ex_regwrite && ex_hit) || (bus.mem_memread && mem_hit))
            need = 2'd1;
        taken = br_taken(bus.br_op, bus.rsgz, bus.tes, bus.rsez);
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall_o  = 1'b0;
        pc_sel_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (active) begin
                    if (need == 2'd0) begin
                        pc_sel_o = taken;
                    end else begin
                        stall_o = 1'b1;
                        cnt_d   = need - 2'd1;
                        state_d = (need > 2'd1) ? ST_STALL : ST_RESOLVE;
                    end
                end
            end
            ST_STALL: begin
                stall_o = 1'b1;
                if (cnt_q != 2'd0) cnt_d = cnt_q - 2'd1;
                state_d = (cnt_q <= 2'd1) ? ST_RESOLVE : ST_STALL;
            end
            ST_RESOLVE: begin
                pc_sel_o = taken;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Outputs read zero while reset is held, even with live hazard inputs.
        if (!rst_n) begin
            stall_o  = 1'b0;
            pc_sel_o = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.stall      = stall_o;
    assign bus.pc_sel     = pc_sel_o;
    assign bus.flush_ifid = pc_sel_o;

    sat_counter #(.W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pc_sel_o),
        .count (taken_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_o),
        .count (stall_cnt)
    );
endmodule
